// File: rtl/slice_cfg_pkg.sv
// slice_cfg_pkg
//   Shared definitions for the slice configuration loader:
//   - cfg_state_t   : loader FSM state encoding
//   - *_f functions : frame geometry derived from S_XX_BASE / NUM_LUTS
//   - USE_CC_BIT / MUX_CFG_LSB : field offsets inside the frame at the
//     default slice geometry (S_XX_BASE=4, NUM_LUTS=4)
package slice_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } cfg_state_t;

    // Width of the LUT truth-table region: two half-LUTs per LUT.
    function automatic int unsigned lut_bits_f(input int unsigned s_xx_base,
                                               input int unsigned num_luts);
        return 2 * ((32'd1 << s_xx_base) + 1) * num_luts;
    endfunction

    // LUT bits + use_cc bit + inter-LUT mux select bits.
    function automatic int unsigned cfg_bits_f(input int unsigned s_xx_base,
                                               input int unsigned num_luts);
        return lut_bits_f(s_xx_base, num_luts) + 1 + $clog2(num_luts);
    endfunction

    function automatic int unsigned num_bytes_f(input int unsigned s_xx_base,
                                                input int unsigned num_luts);
        return (cfg_bits_f(s_xx_base, num_luts) + 7) / 8;
    endfunction

    function automatic int unsigned use_cc_bit_f(input int unsigned s_xx_base,
                                                 input int unsigned num_luts);
        return lut_bits_f(s_xx_base, num_luts);
    endfunction

    function automatic int unsigned mux_cfg_lsb_f(input int unsigned s_xx_base,
                                                  input int unsigned num_luts);
        return lut_bits_f(s_xx_base, num_luts) + 1;
    endfunction

    localparam int unsigned USE_CC_BIT  = use_cc_bit_f(4, 4);
    localparam int unsigned MUX_CFG_LSB = mux_cfg_lsb_f(4, 4);

endpackage

// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader
//   Initiator side of a fracturable-LUT carry slice's config interface.
//   Collects a configuration frame byte by byte (LSB first) from the fabric
//   config controller into a shadow register, then pulses cen for one cclk
//   cycle so the slice latches the whole frame at once.
//
// Ports:
//   cclk            config clock (only clock)
//   rst             asynchronous active-high reset
//   start           begin a new frame (honoured in IDLE and DONE)
//   abort           drop the frame being loaded (honoured in LOAD)
//   data_in         config byte
//   data_valid      data_in valid
//   data_ready      loader accepts a byte this cycle
//   luts_config_out LUT truth tables        -> slice luts_config_in
//   use_cc_out      carry-chain enable       -> slice config_use_cc
//   mux_config_out  inter-LUT mux select     -> slice inter_lut_mux_config
//   cen             one-cycle slice config latch enable
//   busy            high while loading or committing
//   done            frame committed; held until next start
//   frames_loaded   committed-frame count, wraps 255 -> 0
module slice_cfg_loader
    import slice_cfg_pkg::*;
#(
    parameter  int unsigned S_XX_BASE = 4,
    parameter  int unsigned NUM_LUTS  = 4,
    localparam int unsigned CFG_SIZE  = (32'd1 << S_XX_BASE) + 1,
    localparam int unsigned MUX_LVLS  = $clog2(NUM_LUTS),
    localparam int unsigned CFG_BITS  = cfg_bits_f(S_XX_BASE, NUM_LUTS),
    localparam int unsigned NUM_BYTES = num_bytes_f(S_XX_BASE, NUM_LUTS)
) (
    input  logic                             cclk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [7:0]                       data_in,
    input  logic                             data_valid,
    output logic                             data_ready,
    output logic [2*CFG_SIZE*NUM_LUTS-1:0]   luts_config_out,
    output logic                             use_cc_out,
    output logic [MUX_LVLS-1:0]              mux_config_out,
    output logic                             cen,
    output logic                             busy,
    output logic                             done,
    output logic [7:0]                       frames_loaded
);

    localparam int unsigned LUT_W       = 2 * CFG_SIZE * NUM_LUTS;
    localparam int unsigned CC_BIT      = use_cc_bit_f(S_XX_BASE, NUM_LUTS);
    localparam int unsigned MUX_LSB     = mux_cfg_lsb_f(S_XX_BASE, NUM_LUTS);
    localparam int unsigned BCW         = $clog2(NUM_BYTES);

    cfg_state_t         state;
    logic [BCW-1:0]     byte_cnt;
    logic [CFG_BITS-1:0] shadow;
    logic               hs;

    // abort wins over a same-cycle handshake, so the byte is not written.
    assign hs = (state == LOAD) && data_valid && data_ready && !abort;

    // Byte-lane write decoder. The last lane is narrowed so that bits
    // beyond the frame width are never stored.
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        localparam int unsigned LO = 8 * g;
        localparam int unsigned W  = ((CFG_BITS - LO) >= 8) ? 8 : (CFG_BITS - LO);
        logic [W-1:0] lane_q;

        always_ff @(posedge cclk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else if (hs && (byte_cnt == BCW'(g))) begin
                lane_q <= data_in[W-1:0];
            end
        end

        assign shadow[LO +: W] = lane_q;
    end

    assign luts_config_out = shadow[LUT_W-1:0];
    assign use_cc_out      = shadow[CC_BIT];
    assign mux_config_out  = shadow[MUX_LSB +: MUX_LVLS];
    assign busy            = (state == LOAD) || (state == COMMIT);

    // cen is registered alongside the COMMIT transition, so it is high
    // exactly while state == COMMIT and never on two cycles in a row.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            cen           <= 1'b0;
            done          <= 1'b0;
            data_ready    <= 1'b0;
            frames_loaded <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        byte_cnt   <= '0;
                        data_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        byte_cnt   <= '0;
                        data_ready <= 1'b0;
                    end else if (hs) begin
                        if (byte_cnt == BCW'(NUM_BYTES - 1)) begin
                            state      <= COMMIT;
                            cen        <= 1'b1;
                            data_ready <= 1'b0;
                        end
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state         <= DONE;
                    cen           <= 1'b0;
                    done          <= 1'b1;
                    frames_loaded <= frames_loaded + 8'd1;
                end
                DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        byte_cnt   <= '0;
                        done       <= 1'b0;
                        data_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/slice_cfg_loader.md
Name: slice_cfg_loader

Overview:
- Configuration-side driver for the fracturable-LUT carry slice. It is the initiator end of the slice's config interface (config_in buses, config_use_cc, inter_lut_mux_config, cen on cclk).
- Accepts a byte stream from the fabric configuration controller over a valid/ready handshake and assembles one slice config frame in a shadow register.
- Pulses cen for exactly one cclk cycle so the slice latches the whole frame atomically.
- One instance sits beside each slice on the config chain.

Parameters:
- S_XX_BASE, 4: LUT base input count; must match the slice.
- NUM_LUTS, 4: LUTs per slice, power of 2.
- CFG_SIZE, 2**S_XX_BASE+1: config bits per half-LUT (derived).
- MUX_LVLS, $clog2(NUM_LUTS): inter-LUT mux config width (derived).
- CFG_BITS, 2*CFG_SIZE*NUM_LUTS+1+MUX_LVLS: frame width in bits (derived; 139 at defaults).
- NUM_BYTES, (CFG_BITS+7)/8: bytes per frame (derived; 18 at defaults).

Ports:
- cclk  in  1  config clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new frame; sampled in IDLE and DONE only.
- abort  in  1  discard the in-progress frame.
- data_in  in  8  config byte.
- data_valid  in  1  data_in valid.
- data_ready  out  1  loader accepts a byte this cycle.
- luts_config_out  out  2*CFG_SIZE*NUM_LUTS  to slice luts_config_in.
- use_cc_out  out  1  to slice config_use_cc.
- mux_config_out  out  MUX_LVLS  to slice inter_lut_mux_config.
- cen  out  1  slice config latch enable.
- busy  out  1  high in LOAD or COMMIT.
- done  out  1  frame committed; held until the next start.
- frames_loaded  out  8  count of committed frames; wraps at 255 to 0.

Behaviour:
- Reset (async, any state): state=IDLE, byte_cnt=0, shadow=0, cen=0, done=0, data_ready=0, frames_loaded=0.
- Frame packing: byte k fills shadow[8k+7:8k], LSB first. Bits at index CFG_BITS and above in the last byte are discarded (top 5 bits of byte 17 at defaults).
- Shadow slices:
  - shadow[2*CFG_SIZE*NUM_LUTS-1:0] drives luts_config_out.
  - the next bit drives use_cc_out.
  - the next MUX_LVLS bits drive mux_config_out.
  - Outputs are driven combinationally from shadow at all times.
- FSM states: IDLE, LOAD, COMMIT, DONE.
- IDLE: data_ready=0. start=1 moves to LOAD next cycle and clears byte_cnt.
- LOAD: data_ready=1.
  - Handshake fires on data_valid&&data_ready. Write shadow byte byte_cnt, then byte_cnt++.
  - Accepting byte NUM_BYTES-1 moves to COMMIT. data_ready drops the following cycle.
  - data_valid low simply stalls; no timeout.
  - start is ignored in LOAD.
- abort in LOAD: go to IDLE, byte_cnt=0, cen stays 0. Shadow keeps partial data; the slice is unaffected because it never sees cen. abort has priority over a handshake in the same cycle (that byte is dropped).
- COMMIT: cen=1 for exactly one cycle, data_ready=0, frames_loaded++. Next state is DONE. abort is ignored in COMMIT.
- DONE: done=1, data_ready=0. start=1 moves to LOAD, clears done and byte_cnt. Shadow is overwritten byte by byte during reload.
- Latency: cen rises one cycle after the last byte handshake. Minimum frame time is NUM_BYTES+2 cycles from start to cen.
- cen is never asserted outside COMMIT. cen is never high for two consecutive cycles.
- Reset asserted mid-LOAD or mid-COMMIT: cen drops immediately (async), no partial commit.

Decomposition:
- Shared package slice_cfg_pkg holds:
  - state enum (IDLE/LOAD/COMMIT/DONE);
  - functions computing CFG_BITS and NUM_BYTES from S_XX_BASE/NUM_LUTS;
  - field offset constants USE_CC_BIT and MUX_CFG_LSB.
- Single module; no sub-module. The byte-lane write decoder stays inline as a generate loop.

Test Plan:
- Reset then start, 18 bytes 0x00..0x11 back-to-back:
  - cen pulses once, 1 cycle after the 18th handshake.
  - luts_config_out[7:0]=0x00, [15:8]=0x01.
  - use_cc_out=shadow[136]=bit 0 of 0x11=1; mux_config_out=bits 2:1 of 0x11=0.
  - done=1, frames_loaded=1.
- Last byte 0xFF: only bits 138:136 set; use_cc_out=1, mux_config_out=2'b11; no out-of-range write.
- data_valid toggling every other cycle: 18 bytes accepted over ~36 cycles; cen exactly once; outputs as if back-to-back.
- abort after byte 9: state IDLE, cen never asserted, frames_loaded unchanged. A new start plus 18 bytes then commits cleanly.
- rst asserted in the cycle cen=1: cen falls asynchronously; all outputs return to 0; frames_loaded=0.
- 256 full frames: frames_loaded wraps to 0. start held high in LOAD has no effect.
